// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register target
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int FILTER_LEN = 4;

endpackage

// File: rtl/i2c_target_regs_if.sv
// rtl/i2c_target_regs_if.sv - I2C pin and register-write strobe bundle
interface i2c_target_regs_if #(
  parameter int PW = 4
);
  logic          scl_in;
  logic          sda_in;
  logic          sda_oe;
  logic          reg_wr_valid;
  logic [PW-1:0] reg_wr_addr;
  logic [7:0]    reg_wr_data;
  logic          busy;

  modport master (
    output scl_in, sda_in,
    input  sda_oe, reg_wr_valid, reg_wr_addr, reg_wr_data, busy
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, reg_wr_valid, reg_wr_addr, reg_wr_data, busy
  );
endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-flop synchronizer plus stability filter when
// I2C_TARGET_GLITCH_FILTER_EN is defined
module i2c_line_filter
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  logic meta;
  logic sync;

  // Idle I2C lines are high, so reset to 1 to avoid phantom edges
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN);

  logic [CW-1:0] cnt;
  logic          stable;

  // Output follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b1;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign filt = stable;
`else
  assign filt = sync;
`endif

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with auto-incrementing 8-bit register file
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 16
) (
  input logic               clk,
  input logic               reset_n,
  i2c_target_regs_if.slave  bus
);

  localparam int PW = $clog2(NUM_REGS);

  logic scl_s, sda_s, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state, state_n;

  logic [7:0]    shift;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic          ack_bit;
  logic [7:0]    regs [NUM_REGS];
  logic          byte_done;
  logic          addr_match;
  logic [7:0]    wbyte;

  i2c_line_filter u_scl_filt (.clk(clk), .reset_n(reset_n), .raw(bus.scl_in), .filt(scl_s));
  i2c_line_filter u_sda_filt (.clk(clk), .reset_n(reset_n), .raw(bus.sda_in), .filt(sda_s));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  // START/STOP need SCL steady high, so a simultaneous SCL change wins
  assign scl_rise  =  scl_s & ~scl_p;
  assign scl_fall  = ~scl_s &  scl_p;
  assign start_det =  scl_s &  scl_p &  sda_p & ~sda_s;
  assign stop_det  =  scl_s &  scl_p & ~sda_p &  sda_s;

  assign byte_done  = (bit_cnt == 4'd8);
  assign addr_match = (shift[7:1] == DEV_ADDR);
  assign ptr_inc    = ptr + PW'(1);
  assign wbyte      = {shift[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_det) begin
      state_n = ST_ADDR;
    end else if (stop_det) begin
      state_n = ST_IDLE;
    end else if (scl_fall) begin
      case (state)
        ST_ADDR:      if (byte_done) state_n = addr_match ? ST_ADDR_ACK : ST_WAIT;
        ST_ADDR_ACK:  state_n = shift[0] ? ST_RDATA : ST_PTR;
        ST_PTR:       if (byte_done) state_n = ST_PTR_ACK;
        ST_PTR_ACK:   state_n = ST_WDATA;
        ST_WDATA:     if (byte_done) state_n = ST_WDATA_ACK;
        ST_WDATA_ACK: state_n = ST_WDATA;
        ST_RDATA:     if (bit_cnt == 4'd7) state_n = ST_RDATA_ACK;
        ST_RDATA_ACK: state_n = (ack_bit == I2C_ACK) ? ST_RDATA : ST_WAIT;
        default:      state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift            <= '0;
      bit_cnt          <= '0;
      ptr              <= '0;
      ack_bit          <= I2C_NACK;
      bus.sda_oe       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.reg_wr_valid <= 1'b0;
      bus.reg_wr_addr  <= '0;
      bus.reg_wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      bus.reg_wr_valid <= 1'b0;
      if (start_det) begin
        bit_cnt    <= '0;
        bus.sda_oe <= 1'b0;
      end else if (stop_det) begin
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_PTR: begin
            shift   <= wbyte;
            bit_cnt <= bit_cnt + 4'd1;
          end
          ST_WDATA: begin
            shift   <= wbyte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              regs[ptr]        <= wbyte;
              bus.reg_wr_valid <= 1'b1;
              bus.reg_wr_addr  <= ptr;
              bus.reg_wr_data  <= wbyte;
              ptr              <= ptr_inc;
            end
          end
          ST_RDATA_ACK: ack_bit <= sda_s;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ST_ADDR: if (byte_done) begin
            bus.busy   <= addr_match;
            bus.sda_oe <= addr_match ? ~I2C_ACK : 1'b0;
          end
          ST_ADDR_ACK: begin
            bit_cnt <= '0;
            if (shift[0]) begin
              shift      <= regs[ptr];
              bus.sda_oe <= ~regs[ptr][7];
            end else begin
              bus.sda_oe <= 1'b0;
            end
          end
          ST_PTR: if (byte_done) begin
            ptr        <= shift[PW-1:0];
            bus.sda_oe <= ~I2C_ACK;
          end
          ST_WDATA: if (byte_done) bus.sda_oe <= ~I2C_ACK;
          ST_PTR_ACK, ST_WDATA_ACK: begin
            bit_cnt    <= '0;
            bus.sda_oe <= 1'b0;
          end
          ST_RDATA: begin
            if (bit_cnt == 4'd7) begin
              bus.sda_oe <= 1'b0;
            end else begin
              bit_cnt    <= bit_cnt + 4'd1;
              shift      <= {shift[6:0], 1'b0};
              bus.sda_oe <= ~shift[6];
            end
          end
          ST_RDATA_ACK: begin
            if (ack_bit == I2C_ACK) begin
              ptr        <= ptr_inc;
              shift      <= regs[ptr_inc];
              bus.sda_oe <= ~regs[ptr_inc][7];
              bit_cnt    <= '0;
            end else begin
              bus.sda_oe <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bench for i2c_target_regs: bit-banged master, write strobe scoreboard
module tb_i2c_target_regs;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_target_regs_if #(.PW(4)) bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h1A), .NUM_REGS(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam logic EXP_GLITCH_BUSY = 1'b1;
`else
  localparam logic EXP_GLITCH_BUSY = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] ptr_byte;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       acked;
    int         idx0;
    int         idx1;
  } vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t       vecs [5];
  wr_t        exp_q [$];
  logic [7:0] mem [16];
  int         n_total = 0;
  int         n_pass = 0;
  int         oe_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Every bench delay goes through here so strobes are scored as they occur
  task automatic tick(input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.sda_oe === 1'b1) oe_cycles++;
      if (bus.reg_wr_valid === 1'b1) begin
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.reg_wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.reg_wr_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(10);
    sda_m = 1'b0; tick(10);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(5);
    scl_m = 1'b1; tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(5);
      scl_m = 1'b1; tick(10);
      scl_m = 1'b0; tick(5);
    end
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(5);
    ack = bus.sda_in;
    tick(5);
    scl_m = 1'b0; tick(5);
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(5);
      scl_m = 1'b1; tick(5);
      b[i] = bus.sda_in;
      tick(5);
      scl_m = 1'b0; tick(5);
    end
    sda_m = ack; tick(5);
    scl_m = 1'b1; tick(10);
    scl_m = 1'b0; tick(5);
    sda_m = 1'b1;
  endtask

  task automatic do_write(input vec_t v);
    logic a;
    int   oe0;
    logic exp_ack;
    oe0 = oe_cycles;
    exp_ack = v.acked ? 1'b0 : 1'b1;
    i2c_start();
    send_byte(v.addr_byte, a);
    check("addr_ack", a, exp_ack);
    check("busy_after_addr", bus.busy, v.acked);
    send_byte(v.ptr_byte, a);
    check("ptr_ack", a, exp_ack);
    if (v.acked) begin
      exp_q.push_back('{addr: 4'(v.idx0), data: v.d0});
      mem[v.idx0] = v.d0;
    end
    send_byte(v.d0, a);
    check("d0_ack", a, exp_ack);
    if (v.acked) begin
      exp_q.push_back('{addr: 4'(v.idx1), data: v.d1});
      mem[v.idx1] = v.d1;
    end
    send_byte(v.d1, a);
    check("d1_ack", a, exp_ack);
    i2c_stop();
    tick(10);
    check("busy_after_stop", bus.busy, 0);
    check("sb_drained", exp_q.size(), 0);
    if (!v.acked) check("nack_no_pull_low", oe_cycles - oe0, 0);
  endtask

  task automatic do_read(input logic [7:0] p, input logic [7:0] e0, input logic [7:0] e1);
    logic       a;
    logic [7:0] b;
    i2c_start();
    send_byte(8'h34, a);
    check("rd_addr_w_ack", a, 0);
    send_byte(p, a);
    check("rd_ptr_ack", a, 0);
    i2c_start();
    send_byte(8'h35, a);
    check("rd_addr_r_ack", a, 0);
    recv_byte(b, 1'b0);
    check("rd_byte0", b, e0);
    recv_byte(b, 1'b1);
    check("rd_byte1", b, e1);
    tick(10);
    check("oe_after_nack", bus.sda_oe, 0);
    i2c_stop();
    tick(10);
  endtask

  initial begin
    logic a;
    bit   seen;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    vecs[0] = '{8'h34, 8'h03, 8'hA5, 8'h5A, 1'b1, 3, 4};
    vecs[1] = '{8'h34, 8'h0F, 8'h11, 8'h22, 1'b1, 15, 0};
    vecs[2] = '{8'h34, 8'h1F, 8'h33, 8'h44, 1'b1, 15, 0};
    vecs[3] = '{8'h36, 8'h05, 8'h77, 8'h88, 1'b0, 5, 6};
    vecs[4] = '{8'h34, 8'h08, 8'hC3, 8'h3C, 1'b1, 8, 9};

    reset_n = 1'b0;
    tick(5);
    reset_n = 1'b1;
    tick(5);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_wr_valid", bus.reg_wr_valid, 0);
    check("rst_wr_addr", 32'(bus.reg_wr_addr), 0);
    check("rst_wr_data", 32'(bus.reg_wr_data), 0);
    check("rst_busy", bus.busy, 0);

    for (int v = 0; v < 5; v++) begin
      do_write(vecs[v]);
      do_read(vecs[v].ptr_byte, mem[vecs[v].idx0], mem[(vecs[v].idx0 + 1) % 16]);
    end

    // Reset while the target is pulling SDA low for bit 6 of 0xA5
    i2c_start();
    send_byte(8'h34, a);
    send_byte(8'h03, a);
    i2c_start();
    send_byte(8'h35, a);
    check("mid_rd_addr_ack", a, 0);
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(10);
    scl_m = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(1);
      if (bus.sda_oe === 1'b1) seen = 1'b1;
    end
    check("mid_rd_zero_driven", seen, 1);
    reset_n = 1'b0;
    tick(1);
    check("mid_rd_oe_released", bus.sda_oe, 0);
    check("mid_rd_busy_cleared", bus.busy, 0);
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    scl_m = 1'b1; tick(10);
    do_read(8'h03, 8'h00, 8'h00);
    do_write(vecs[0]);
    do_read(8'h03, mem[3], mem[4]);

    // Short SDA glitch while SCL is high in the middle of a transaction
    i2c_start();
    send_byte(8'h34, a);
    check("glitch_addr_ack", a, 0);
    sda_m = 1'b1; tick(5);
    scl_m = 1'b1; tick(3);
    sda_m = 1'b0; tick(2);
    sda_m = 1'b1; tick(5);
    check("glitch_busy", bus.busy, EXP_GLITCH_BUSY);
    scl_m = 1'b0; tick(5);
    i2c_stop();
    tick(10);
    check("glitch_busy_after_stop", bus.busy, 0);
    check("final_sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
